// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial WIDTH-bit two's-complement adder/subtractor.
//               One full-adder slice plus a carry flop, LSB first, one bit
//               per clock, behind a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int            CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;          // already inverted for subtraction
    logic             r_c;
    logic [CW-1:0]    r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_abit;
    logic             w_bbit;
    logic             w_sum;
    logic             w_cnext;
    logic [WIDTH-1:0] w_result_next;

    // DONE accepts a new request just like IDLE; RUN ignores start.
    assign w_accept = start && (r_state != c_RUN);
    assign w_last   = (r_idx == c_LAST);

    // Single full-adder slice working on the current bit position.
    always_comb begin
        w_abit        = r_a[r_idx];
        w_bbit        = r_b[r_idx];
        w_sum         = w_abit ^ w_bbit ^ r_c;
        w_cnext       = (w_abit & w_bbit) | (w_abit & r_c) | (w_bbit & r_c);
        w_result_next = r_result;
        w_result_next[r_idx] = w_sum;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a request runs WIDTH bit steps, then one DONE cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  w_next_state = start ? c_RUN : c_IDLE;
            c_RUN:   w_next_state = w_last ? c_DONE : c_RUN;
            c_DONE:  w_next_state = start ? c_RUN : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_RUN:   busy = 1'b1;
            c_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand latch, serial datapath and flag capture on the MSB step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= subtract ? ~b : b;
            r_c      <= subtract;           // +1 completes the two's complement
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (r_state == c_RUN) begin
            r_result <= w_result_next;
            r_c      <= w_cnext;
            if (w_last) begin
                r_cout <= w_cnext;
                r_ovf  <= r_c ^ w_cnext;    // carry into MSB xor carry out
                r_zero <= (w_result_next == '0);
            end else begin
                r_idx  <= r_idx + 1'b1;     // parks at the MSB, never wraps
            end
        end
    end

    assign result   = r_result;
    assign carryout = r_cout;
    assign overflow = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire
